// File: rtl/timebin_uart_packer.sv
// Timebin count FIFO + 8N1 UART packetiser: each 16-bit count goes out high byte first.
// Define SEQ_TAG_EN to append an 8-bit per-strobe sequence number as a third byte.
module timebin_uart_packer #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bin_strobe,
  input  logic [15:0]              bin_count,
  input  logic                     run,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
`ifdef SEQ_TAG_EN
  localparam int W  = 24;
  localparam int NB = 3;
`else
  localparam int W  = 16;
  localparam int NB = 2;
`endif
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic [W-1:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]               wdata, hold;
  logic [BW-1:0]              baud_cnt;
  logic [2:0]                 bit_idx;
  logic [1:0]                 byte_idx;
  logic [7:0]                 cur_byte;
  logic                       push, pop, full, baud_done, last_byte;

  assign full      = (fifo_level == (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign push      = bin_strobe && run && !full;
  assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == 2'(NB - 1));

`ifdef SEQ_TAG_EN
  logic [7:0] seq;
  // Dropped samples still consume a sequence number so the host sees the gap.
  always_ff @(posedge clk) begin
    if (reset)                  seq <= '0;
    else if (bin_strobe && run) seq <= seq + 8'd1;
  end
  assign wdata = {bin_count, seq};
`else
  assign wdata = bin_count;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (bin_strobe && run && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if (state == LOAD) begin
        hold     <= mem[rd_ptr];
        byte_idx <= '0;
      end else if (state == STOP && baud_done && !last_byte) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == START || state == DATA || state == STOP)
        baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
      else
        baud_cnt <= '0;
      // 3-bit index wraps back to 0 after bit 7, ready for the next byte.
      if (state == DATA) begin
        if (baud_done) bit_idx <= bit_idx + 3'd1;
      end else begin
        bit_idx <= '0;
      end
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = hold[W-1 -: 8];
      2'd1:    cur_byte = hold[W-9 -: 8];
      default: cur_byte = hold[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fifo_level != '0) state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (baud_done) state_nxt = last_byte ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    pop  = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      LOAD:    pop  = 1'b1;
      START:   tx   = 1'b0;
      DATA:    tx   = cur_byte[bit_idx];
      default: tx   = 1'b1;
    endcase
  end
endmodule
